// File: rtl/commit_trace_buf_if.sv
// Commit-record input and trace-record output bundle for commit_trace_buf.
// The slave modport is the buffer's view; master is the core/sink environment view.
interface commit_trace_buf_if #(
   parameter int XLEN = 64,
   parameter int ILEN = 32
);
   logic            cm_valid_i;
   logic [XLEN-1:0] cm_pc_i;
   logic [ILEN-1:0] cm_ir_i;
   logic            cm_rf_we_i;
   logic [4:0]      cm_rd_i;
   logic [XLEN-1:0] cm_wdata_i;

   logic            tr_valid_o;
   logic            tr_ready_i;
   logic [XLEN-1:0] tr_pc_o;
   logic [ILEN-1:0] tr_ir_o;
   logic            tr_rf_we_o;
   logic [4:0]      tr_rd_o;
   logic [XLEN-1:0] tr_wdata_o;

   modport slave (
      input  cm_valid_i, cm_pc_i, cm_ir_i, cm_rf_we_i, cm_rd_i, cm_wdata_i, tr_ready_i,
      output tr_valid_o, tr_pc_o, tr_ir_o, tr_rf_we_o, tr_rd_o, tr_wdata_o
   );

   modport master (
      output cm_valid_i, cm_pc_i, cm_ir_i, cm_rf_we_i, cm_rd_i, cm_wdata_i, tr_ready_i,
      input  tr_valid_o, tr_pc_o, tr_ir_o, tr_rf_we_o, tr_rd_o, tr_wdata_o
   );
endinterface

// File: rtl/commit_trace_buf.sv
// First-word-fall-through buffer for commit trace records with drop/commit
// counters and UNIMP end-of-program halt detection.
module commit_trace_buf #(
   parameter int XLEN  = 64,
   parameter int ILEN  = 32,
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   commit_trace_buf_if.slave          bus,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic [63:0]                commit_cnt_o,
   output logic [31:0]                drop_cnt_o,
   output logic                       overflow_o,
   output logic                       halt_o,
   output logic                       drained_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int RW = XLEN + ILEN + 1 + 5 + XLEN;
   localparam logic [ILEN-1:0] UNIMP_IR = ILEN'(32'hC000_1073);

   logic [RW-1:0]   mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [63:0]     commit_cnt_q, commit_cnt_d;
   logic [31:0]     drop_cnt_q, drop_cnt_d;
   logic            overflow_q, overflow_d;
   logic            halt_q, halt_d;

   logic            full_s, empty_s, push_s, pop_s, drop_s;
   logic [RW-1:0]   wr_rec_s, rd_rec_s;

   assign full_s   = (count_q == CW'(DEPTH));
   assign empty_s  = (count_q == {CW{1'b0}});
   assign wr_rec_s = {bus.cm_pc_i, bus.cm_ir_i, bus.cm_rf_we_i, bus.cm_rd_i, bus.cm_wdata_i};
   assign rd_rec_s = mem_q[rd_ptr_q];

   // Handshake decode and next-state for pointers, occupancy, counters and sticky flags.
   always_comb begin
      pop_s        = !empty_s && bus.tr_ready_i;
      push_s       = bus.cm_valid_i && !halt_q && (!full_s || pop_s);
      drop_s       = bus.cm_valid_i && !halt_q && full_s && !pop_s;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      commit_cnt_d = commit_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      overflow_d   = overflow_q;
      halt_d       = halt_q;

      if (push_s) begin
         wr_ptr_d     = wr_ptr_q + PW'(1);
         commit_cnt_d = commit_cnt_q + 64'd1;
         halt_d       = halt_q || (bus.cm_ir_i == UNIMP_IR);
      end else begin
         wr_ptr_d     = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // The drop counter sticks at all-ones instead of wrapping back to a misleading small value.
      if (drop_s) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 32'hFFFF_FFFF) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
         end else begin
            drop_cnt_d = drop_cnt_q;
         end
      end else begin
         overflow_d = overflow_q;
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Control state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q     <= {PW{1'b0}};
         rd_ptr_q     <= {PW{1'b0}};
         count_q      <= {CW{1'b0}};
         commit_cnt_q <= 64'd0;
         drop_cnt_q   <= 32'd0;
         overflow_q   <= 1'b0;
         halt_q       <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         commit_cnt_q <= commit_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         overflow_q   <= overflow_d;
         halt_q       <= halt_d;
      end
   end

   // Record storage carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= wr_rec_s;
      end
   end

   assign bus.tr_valid_o = !empty_s;
   assign {bus.tr_pc_o, bus.tr_ir_o, bus.tr_rf_we_o, bus.tr_rd_o, bus.tr_wdata_o} = rd_rec_s;

   assign count_o      = count_q;
   assign commit_cnt_o = commit_cnt_q;
   assign drop_cnt_o   = drop_cnt_q;
   assign overflow_o   = overflow_q;
   assign halt_o       = halt_q;
   assign drained_o    = halt_q && empty_s;
endmodule

// File: tb/tb_commit_trace_buf.sv
// Randomized and directed bench for commit_trace_buf against a queue-based
// reference model of the buffer's observable behaviour.
module tb_commit_trace_buf;
   localparam int DEPTH = 16;
   localparam logic [31:0] UNIMP = 32'hC000_1073;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] ir;
      logic        we;
      logic [4:0]  rd;
      logic [63:0] wd;
   } rec_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [4:0]  count_o;
   logic [63:0] commit_cnt_o;
   logic [31:0] drop_cnt_o;
   logic        overflow_o, halt_o, drained_o;

   commit_trace_buf_if #(.XLEN(64), .ILEN(32)) bus ();

   commit_trace_buf #(.XLEN(64), .ILEN(32), .DEPTH(DEPTH)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .bus          (bus),
      .count_o      (count_o),
      .commit_cnt_o (commit_cnt_o),
      .drop_cnt_o   (drop_cnt_o),
      .overflow_o   (overflow_o),
      .halt_o       (halt_o),
      .drained_o    (drained_o)
   );

   always #5 clk_i = ~clk_i;

   int          checks_q = 0;
   int          failures_q = 0;

   rec_t        mdl_q[$];
   logic [63:0] mdl_commit = 64'd0;
   int unsigned mdl_drop = 0;
   logic        mdl_ovf = 1'b0;
   logic        mdl_halt = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_q++;
      if (got !== exp) begin
         failures_q++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      rec_t h;
      chk("count", 64'(count_o), 64'(mdl_q.size()));
      chk("tr_valid", 64'(bus.tr_valid_o), 64'(mdl_q.size() != 0));
      if (mdl_q.size() != 0) begin
         h = mdl_q[0];
         chk("tr_pc", bus.tr_pc_o, h.pc);
         chk("tr_ir", 64'(bus.tr_ir_o), 64'(h.ir));
         chk("tr_we_rd", 64'({bus.tr_rf_we_o, bus.tr_rd_o}), 64'({h.we, h.rd}));
         chk("tr_wdata", bus.tr_wdata_o, h.wd);
      end
      chk("commit_cnt", commit_cnt_o, mdl_commit);
      chk("drop_cnt", 64'(drop_cnt_o), 64'(mdl_drop));
      chk("overflow", 64'(overflow_o), 64'(mdl_ovf));
      chk("halt", 64'(halt_o), 64'(mdl_halt));
      chk("drained", 64'(drained_o), 64'(mdl_halt && mdl_q.size() == 0));
   endtask

   // One clock cycle: drive inputs, predict, clock, update model, compare.
   task automatic step(input logic v, input rec_t r, input logic rdy);
      logic pop, push, drop, full;
      bus.cm_valid_i = v;
      bus.cm_pc_i    = r.pc;
      bus.cm_ir_i    = r.ir;
      bus.cm_rf_we_i = r.we;
      bus.cm_rd_i    = r.rd;
      bus.cm_wdata_i = r.wd;
      bus.tr_ready_i = rdy;
      full = (mdl_q.size() == DEPTH);
      pop  = (mdl_q.size() != 0) && rdy;
      push = v && !mdl_halt && (!full || pop);
      drop = v && !mdl_halt && full && !pop;
      @(posedge clk_i);
      #1;
      if (pop) void'(mdl_q.pop_front());
      if (push) begin
         mdl_q.push_back(r);
         mdl_commit = mdl_commit + 64'd1;
         if (r.ir == UNIMP) mdl_halt = 1'b1;
      end
      if (drop) begin
         mdl_ovf = 1'b1;
         if (mdl_drop != 32'hFFFF_FFFF) mdl_drop++;
      end
      check_all();
   endtask

   function automatic rec_t rand_rec();
      rec_t r;
      r.pc = {$urandom, $urandom};
      r.ir = $urandom;
      if (r.ir == UNIMP) r.ir = r.ir ^ 32'h0000_0001;
      r.we = 1'($urandom);
      r.rd = 5'($urandom);
      r.wd = {$urandom, $urandom};
      return r;
   endfunction

   function automatic rec_t seq_rec(input int n);
      rec_t r;
      r = rand_rec();
      r.pc = 64'h8000_0000 + 64'(n) * 64'd4;
      return r;
   endfunction

   task automatic model_reset();
      mdl_q.delete();
      mdl_commit = 64'd0;
      mdl_drop   = 0;
      mdl_ovf    = 1'b0;
      mdl_halt   = 1'b0;
   endtask

   rec_t r0;

   initial begin
      bus.cm_valid_i = 1'b0;
      bus.cm_pc_i    = 64'd0;
      bus.cm_ir_i    = 32'd0;
      bus.cm_rf_we_i = 1'b0;
      bus.cm_rd_i    = 5'd0;
      bus.cm_wdata_i = 64'd0;
      bus.tr_ready_i = 1'b0;

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      check_all();
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Single push then pop
      r0 = '{pc: 64'h8000_0000, ir: 32'h0000_0013, we: 1'b1, rd: 5'd1, wd: 64'h1234};
      step(1'b1, r0, 1'b1);
      chk("t1_valid", 64'(bus.tr_valid_o), 64'd1);
      chk("t1_pc", bus.tr_pc_o, 64'h8000_0000);
      step(1'b0, r0, 1'b1);
      chk("t1_count", 64'(count_o), 64'd0);
      chk("t1_commit", commit_cnt_o, 64'd1);

      // Overflow: 20 pushes with sink stalled, then drain
      for (int i = 0; i < 20; i++) step(1'b1, seq_rec(i), 1'b0);
      chk("t2_count", 64'(count_o), 64'd16);
      chk("t2_drop", 64'(drop_cnt_o), 64'd4);
      chk("t2_ovf", 64'(overflow_o), 64'd1);
      chk("t2_commit", commit_cnt_o, 64'd17);
      for (int i = 0; i < 16; i++) begin
         chk("t2_order", bus.tr_pc_o, 64'h8000_0000 + 64'(i) * 64'd4);
         step(1'b0, r0, 1'b1);
      end

      // Full FIFO with simultaneous push and pop, wrapping pointers
      for (int i = 0; i < 16; i++) step(1'b1, seq_rec(100 + i), 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, seq_rec(200 + i), 1'b1);
         chk("t3_count", 64'(count_o), 64'd16);
      end
      chk("t3_drop", 64'(drop_cnt_o), 64'd4);
      while (mdl_q.size() != 0) step(1'b0, r0, 1'b1);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 7; i++) step(1'b1, rand_rec(), 1'b0);
      chk("t5_pre_count", 64'(count_o), 64'd7);
      #2;
      rst_ni = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 10000; i++) begin
         step(($urandom_range(0, 99) < 50), rand_rec(), ($urandom_range(0, 99) < 30));
      end

      // Halt on UNIMP, later commits ignored, drain
      while (mdl_q.size() != 0) step(1'b0, r0, 1'b1);
      step(1'b1, rand_rec(), 1'b0);
      r0 = rand_rec();
      r0.ir = UNIMP;
      step(1'b1, r0, 1'b0);
      chk("t4_halt", 64'(halt_o), 64'd1);
      for (int i = 0; i < 3; i++) step(1'b1, rand_rec(), 1'b0);
      chk("t4_count", 64'(count_o), 64'd2);
      chk("t4_drained_early", 64'(drained_o), 64'd0);
      step(1'b0, r0, 1'b1);
      chk("t4_head_unimp", 64'(bus.tr_ir_o), 64'(UNIMP));
      step(1'b0, r0, 1'b1);
      chk("t4_drained", 64'(drained_o), 64'd1);
      step(1'b1, rand_rec(), 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
      $finish;
   end
endmodule
